multi_digit_bcd_display: RTL

//  Converts an unsigned binary value (score/timer) into DIGITS decimal digits and drives

---
 rtl/multi_digit_bcd_display_pkg.sv | 35 +++
 rtl/multi_digit_bcd_display_seg7_encode.sv | 33 +++
 rtl/multi_digit_bcd_display.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/multi_digit_bcd_display_pkg.sv
// Shared definitions for the BCD display block: segment codes, FSM state
// encodings and a constant helper for the decimal overflow limit.
package multi_digit_bcd_display_pkg;

  // Active-high segment codes, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0     = 7'b0111111;
  localparam logic [6:0] SEG_1     = 7'b0000110;
  localparam logic [6:0] SEG_2     = 7'b1011011;
  localparam logic [6:0] SEG_3     = 7'b1001111;
  localparam logic [6:0] SEG_4     = 7'b1100110;
  localparam logic [6:0] SEG_5     = 7'b1101101;
  localparam logic [6:0] SEG_6     = 7'b1111101;
  localparam logic [6:0] SEG_7     = 7'b0000111;
  localparam logic [6:0] SEG_8     = 7'b1111111;
  localparam logic [6:0] SEG_9     = 7'b1101111;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_DASH  = 7'b1000000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_UPDATE = 2'd2
  } state_t;

  // 10**n, used to decide at capture time whether a value fits the digits
  function automatic logic [63:0] pow10(input int n);
    logic [63:0] r;
    r = 64'd1;
    for (int i = 0; i < n; i++) begin
      r = r * 64'd10;
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_digit_bcd_display_seg7_encode.sv
// One decimal digit to active-high seven-segment code. Non-decimal nibbles
// render blank so a corrupted digit never shows a misleading number.
module seg7_encode
  import multi_digit_bcd_display_pkg::*;
(
  input  logic [3:0] digit,
  input  logic       blank,
  output logic [6:0] seg
);

  // Map the digit to its segment pattern, forcing blank when requested
  always_comb begin
    seg = SEG_BLANK;
    if (blank) begin
      seg = SEG_BLANK;
    end else begin
      case (digit)
        4'd0:    seg = SEG_0;
        4'd1:    seg = SEG_1;
        4'd2:    seg = SEG_2;
        4'd3:    seg = SEG_3;
        4'd4:    seg = SEG_4;
        4'd5:    seg = SEG_5;
        4'd6:    seg = SEG_6;
        4'd7:    seg = SEG_7;
        4'd8:    seg = SEG_8;
        4'd9:    seg = SEG_9;
        default: seg = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/multi_digit_bcd_display.sv
// Binary to multi-digit seven-segment display driver. A sequential
// double-dabble converts one bit per clock; the displayed result only
// changes in the UPDATE state so the panel never flickers mid-conversion.
module multi_digit_bcd_display
  import multi_digit_bcd_display_pkg::*;
#(
  parameter int BIN_WIDTH  = 10,
  parameter int DIGITS     = 3,
  parameter int BLANK_LEAD = 1,
  parameter int ACTIVE_LOW = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [BIN_WIDTH-1:0]  value,
  input  logic                  load,
  input  logic                  enable,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic [7*DIGITS-1:0]   hex
);

  localparam int CW = $clog2(BIN_WIDTH + 1);
  localparam int HW = 7 * DIGITS;
  localparam int BW4 = 4 * DIGITS;
  localparam logic [63:0]   LIMIT    = pow10(DIGITS);
  localparam logic [HW-1:0] POL_MASK = {HW{(ACTIVE_LOW != 0)}};
  localparam logic [HW-1:0] DASH_ALL = {DIGITS{SEG_DASH}};

  state_t                state_r, state_nxt_s;
  logic [BIN_WIDTH-1:0]  bin_r, bin_nxt_s;
  logic [BW4-1:0]        bcd_r, bcd_nxt_s, bcd_adj_s;
  logic [CW-1:0]         cnt_r, cnt_nxt_s;
  logic                  busy_r, busy_nxt_s;
  logic                  done_r, done_nxt_s;
  logic                  ovf_r, ovf_nxt_s;
  logic                  ovf_cap_r, ovf_cap_nxt_s;
  logic [HW-1:0]         hex_r, hex_nxt_s;
  logic [HW-1:0]         enc_s;
  logic [DIGITS-1:0]     blank_s;

  // Double-dabble adjust: every nibble of 5 or more gets +3 before the shift
  always_comb begin
    bcd_adj_s = bcd_r;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_r[4*k +: 4] >= 4'd5) begin
        bcd_adj_s[4*k +: 4] = bcd_r[4*k +: 4] + 4'd3;
      end else begin
        bcd_adj_s[4*k +: 4] = bcd_r[4*k +: 4];
      end
    end
  end

  // Leading-zero blanking: a digit blanks when it and all above it are zero;
  // digit 0 always shows so a zero result reads "0"
  always_comb begin : blank_calc
    logic zero_above;
    zero_above = 1'b1;
    blank_s    = '0;
    for (int k = DIGITS - 1; k >= 0; k--) begin
      zero_above = zero_above && (bcd_r[4*k +: 4] == 4'd0);
      if ((BLANK_LEAD != 0) && zero_above && (k != 0)) begin
        blank_s[k] = 1'b1;
      end else begin
        blank_s[k] = 1'b0;
      end
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_enc
    seg7_encode u_enc (
      .digit (bcd_r[4*g +: 4]),
      .blank (blank_s[g]),
      .seg   (enc_s[7*g +: 7])
    );
  end

  // Next-state and datapath logic for IDLE -> SHIFT -> UPDATE
  always_comb begin
    state_nxt_s   = state_r;
    bin_nxt_s     = bin_r;
    bcd_nxt_s     = bcd_r;
    cnt_nxt_s     = cnt_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    ovf_nxt_s     = ovf_r;
    ovf_cap_nxt_s = ovf_cap_r;
    hex_nxt_s     = hex_r;
    case (state_r)
      ST_IDLE: begin
        if (load) begin
          bin_nxt_s     = value;
          bcd_nxt_s     = '0;
          cnt_nxt_s     = '0;
          busy_nxt_s    = 1'b1;
          ovf_cap_nxt_s = (64'(value) >= LIMIT);
          state_nxt_s   = ST_SHIFT;
        end else begin
          state_nxt_s   = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        {bcd_nxt_s, bin_nxt_s} = {bcd_adj_s, bin_r} << 1;
        cnt_nxt_s = cnt_r + CW'(1);
        if (cnt_r == CW'(BIN_WIDTH - 1)) begin
          state_nxt_s = ST_UPDATE;
        end else begin
          state_nxt_s = ST_SHIFT;
        end
      end
      ST_UPDATE: begin
        if (ovf_cap_r) begin
          hex_nxt_s = DASH_ALL;
        end else begin
          hex_nxt_s = enc_s;
        end
        ovf_nxt_s   = ovf_cap_r;
        done_nxt_s  = 1'b1;
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
      default: begin
        busy_nxt_s  = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and result registers; reset aborts any conversion silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= ST_IDLE;
      bin_r     <= '0;
      bcd_r     <= '0;
      cnt_r     <= '0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      ovf_r     <= 1'b0;
      ovf_cap_r <= 1'b0;
      hex_r     <= '0;
    end else begin
      state_r   <= state_nxt_s;
      bin_r     <= bin_nxt_s;
      bcd_r     <= bcd_nxt_s;
      cnt_r     <= cnt_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      ovf_r     <= ovf_nxt_s;
      ovf_cap_r <= ovf_cap_nxt_s;
      hex_r     <= hex_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign overflow = ovf_r;
  // Display enable gates the held result straight through, polarity applied last
  assign hex      = enable ? (hex_r ^ POL_MASK) : POL_MASK;

endmodule
